// File: rtl/bp_resolve_ctrl.sv
// Branch-resolution scheduler: in-flight branch FIFO, predictor update strobe, mispredict flush/redirect/GHR restore.
// Optional resolve/mispredict statistics counters are built when BP_STATS_EN is defined.
module bp_resolve_ctrl #(
  parameter int DEPTH    = 4,
  parameter int GHR_BITS = 8,
  parameter int PC_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  output logic                pred_ready,
  input  logic [PC_W-1:0]     pred_pc,
  input  logic                pred_taken,
  input  logic [PC_W-1:0]     pred_target,
  input  logic [GHR_BITS-1:0] pred_ghr,
  input  logic                res_valid,
  input  logic                res_taken,
  input  logic [PC_W-1:0]     res_target,
  output logic                upd_valid,
  output logic [GHR_BITS-1:0] upd_addr,
  output logic                upd_taken,
  output logic                ghr_restore_valid,
  output logic [GHR_BITS-1:0] ghr_restore,
  output logic                flush,
  output logic [PC_W-1:0]     redirect_pc,
  output logic                res_err
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispred
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [PC_W-1:0]     r_pcMem     [DEPTH];
  logic                r_takenMem  [DEPTH];
  logic [PC_W-1:0]     r_targetMem [DEPTH];
  logic [GHR_BITS-1:0] r_ghrMem    [DEPTH];

  logic [PTR_W-1:0] r_headPtr;
  logic [PTR_W-1:0] r_tailPtr;
  logic [CNT_W-1:0] r_count;

  logic                w_enq;
  logic                w_resolve;
  logic                w_err;
  logic                w_mispred;
  logic [PC_W-1:0]     w_headPc;
  logic                w_headTaken;
  logic [PC_W-1:0]     w_headTarget;
  logic [GHR_BITS-1:0] w_headGhr;

  assign w_headPc     = r_pcMem[r_headPtr];
  assign w_headTaken  = r_takenMem[r_headPtr];
  assign w_headTarget = r_targetMem[r_headPtr];
  assign w_headGhr    = r_ghrMem[r_headPtr];

  // No bypass when full: a pop in the same cycle does not open a slot.
  assign pred_ready = (r_count != CNT_W'(DEPTH)) && (r_state == RUN);
  assign w_enq      = pred_valid && pred_ready;
  assign w_resolve  = (r_state == RUN) && res_valid && (r_count != '0);
  assign w_err      = (r_state == RUN) && res_valid && (r_count == '0);
  assign w_mispred  = w_resolve &&
                      ((res_taken != w_headTaken) ||
                       (res_taken && (res_target != w_headTarget)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN:     if (w_mispred) w_nextState = RECOVER;
      RECOVER: w_nextState = RUN;
      default: w_nextState = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pcMem[r_tailPtr]     <= pred_pc;
      r_takenMem[r_tailPtr]  <= pred_taken;
      r_targetMem[r_tailPtr] <= pred_target;
      r_ghrMem[r_tailPtr]    <= pred_ghr;
    end
  end

  // A mispredict empties the queue and drops any same-cycle enqueue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_headPtr <= '0;
      r_tailPtr <= '0;
      r_count   <= '0;
    end else if (w_mispred) begin
      r_tailPtr <= r_headPtr;
      r_count   <= '0;
    end else begin
      if (w_enq)     r_tailPtr <= r_tailPtr + PTR_W'(1);
      if (w_resolve) r_headPtr <= r_headPtr + PTR_W'(1);
      case ({w_enq, w_resolve})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid         <= 1'b0;
      upd_addr          <= '0;
      upd_taken         <= 1'b0;
      ghr_restore_valid <= 1'b0;
      ghr_restore       <= '0;
      flush             <= 1'b0;
      redirect_pc       <= '0;
      res_err           <= 1'b0;
    end else begin
      upd_valid         <= w_resolve;
      ghr_restore_valid <= w_mispred;
      flush             <= w_mispred;
      res_err           <= w_err;
      if (w_resolve) begin
        upd_addr  <= w_headPc[GHR_BITS+1:2];
        upd_taken <= res_taken;
      end
      if (w_mispred) begin
        ghr_restore <= {w_headGhr[GHR_BITS-2:0], res_taken};
        redirect_pc <= res_taken ? res_target : (w_headPc + PC_W'(4));
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (w_resolve && (stat_branches != 32'hFFFF_FFFF)) stat_branches <= stat_branches + 32'd1;
      if (w_mispred && (stat_mispred != 32'hFFFF_FFFF))  stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// Scoreboard bench for bp_resolve_ctrl: stimulus pushes expected strobes, a negedge monitor pops and compares.
// Stats outputs are checked when BP_STATS_EN is defined.
module tb_bp_resolve_ctrl;

  localparam int DEPTH    = 4;
  localparam int GHR_BITS = 8;
  localparam int PC_W     = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                pred_valid = 1'b0;
  logic                pred_ready;
  logic [PC_W-1:0]     pred_pc = '0;
  logic                pred_taken = 1'b0;
  logic [PC_W-1:0]     pred_target = '0;
  logic [GHR_BITS-1:0] pred_ghr = '0;
  logic                res_valid = 1'b0;
  logic                res_taken = 1'b0;
  logic [PC_W-1:0]     res_target = '0;
  logic                upd_valid;
  logic [GHR_BITS-1:0] upd_addr;
  logic                upd_taken;
  logic                ghr_restore_valid;
  logic [GHR_BITS-1:0] ghr_restore;
  logic                flush;
  logic [PC_W-1:0]     redirect_pc;
  logic                res_err;
`ifdef BP_STATS_EN
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispred;
`endif

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic                updValid;
    logic [GHR_BITS-1:0] updAddr;
    logic                updTaken;
    logic                flush;
    logic [PC_W-1:0]     redirect;
    logic [GHR_BITS-1:0] ghr;
    logic                err;
  } exp_t;

  exp_t sbQ[$];

  bp_resolve_ctrl #(.DEPTH(DEPTH), .GHR_BITS(GHR_BITS), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .ghr_restore_valid(ghr_restore_valid), .ghr_restore(ghr_restore),
    .flush(flush), .redirect_pc(redirect_pc), .res_err(res_err)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, returns 1 time unit after the sampling edge with inputs idle.
  task automatic applyStimulus(input logic pv, input logic [PC_W-1:0] pPc, input logic pTaken,
                               input logic [PC_W-1:0] pTarget, input logic [GHR_BITS-1:0] pGhr,
                               input logic rv, input logic rTaken, input logic [PC_W-1:0] rTarget);
    pred_valid  = pv;
    pred_pc     = pPc;
    pred_taken  = pTaken;
    pred_target = pTarget;
    pred_ghr    = pGhr;
    res_valid   = rv;
    res_taken   = rTaken;
    res_target  = rTarget;
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushExp(input logic uv, input logic [GHR_BITS-1:0] addr, input logic tk,
                         input logic fl, input logic [PC_W-1:0] rd, input logic [GHR_BITS-1:0] gh,
                         input logic er);
    exp_t e;
    e.updValid = uv; e.updAddr = addr; e.updTaken = tk;
    e.flush = fl; e.redirect = rd; e.ghr = gh; e.err = er;
    sbQ.push_back(e);
  endtask

  task automatic enqueue(input logic [PC_W-1:0] pc, input logic tk, input logic [PC_W-1:0] tgt,
                         input logic [GHR_BITS-1:0] gh);
    applyStimulus(1'b1, pc, tk, tgt, gh, 1'b0, 1'b0, '0);
  endtask

  // Monitor: any strobe must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && (upd_valid || flush || ghr_restore_valid || res_err)) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedStrobe", {28'd0, upd_valid, flush, ghr_restore_valid, res_err}, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("upd_valid", 32'(upd_valid), 32'(e.updValid));
        if (e.updValid) begin
          checkOutput("upd_addr", 32'(upd_addr), 32'(e.updAddr));
          checkOutput("upd_taken", 32'(upd_taken), 32'(e.updTaken));
        end
        checkOutput("flush", 32'(flush), 32'(e.flush));
        checkOutput("ghr_restore_valid", 32'(ghr_restore_valid), 32'(e.flush));
        if (e.flush) begin
          checkOutput("redirect_pc", redirect_pc, e.redirect);
          checkOutput("ghr_restore", 32'(ghr_restore), 32'(e.ghr));
        end
        checkOutput("res_err", 32'(res_err), 32'(e.err));
      end
    end
  end

  initial begin
    #3;
    checkOutput("resetReady", 32'(pred_ready), 32'd1);
    checkOutput("resetStrobes", {28'd0, upd_valid, flush, ghr_restore_valid, res_err}, 32'd0);
    checkOutput("resetRedirect", redirect_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Correct not-taken resolve, then enqueue plus correct resolve in the same cycle.
    enqueue(32'h100, 1'b0, 32'h0, 8'h00);
    pushExp(1'b1, 8'h40, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 32'h104, 1'b0, 32'h0, 8'h01, 1'b1, 1'b0, 32'h0);
    pushExp(1'b1, 8'h41, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    idleCycles(2);
    checkOutput("readyAfterCorrect", 32'(pred_ready), 32'd1);

    // Wrong target: flush, redirect to actual target, one RECOVER cycle ignoring inputs.
    enqueue(32'h200, 1'b1, 32'h300, 8'h00);
    pushExp(1'b1, 8'h80, 1'b1, 1'b1, 32'h304, 8'h01, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h304);
    checkOutput("recoverReady", 32'(pred_ready), 32'd0);
    applyStimulus(1'b1, 32'h500, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    checkOutput("readyAfterRecover", 32'(pred_ready), 32'd1);
    idleCycles(1);

    // Wrong direction (predicted taken, actually not): redirect to pc+4.
    enqueue(32'h10, 1'b1, 32'h80, 8'hA5);
    pushExp(1'b1, 8'h04, 1'b0, 1'b1, 32'h14, 8'h4A, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    idleCycles(2);

    // Fill the queue; a correct resolve while full must not admit the new entry.
    enqueue(32'h40, 1'b0, 32'h0, 8'h10);
    enqueue(32'h44, 1'b0, 32'h0, 8'h11);
    enqueue(32'h48, 1'b1, 32'h90, 8'h12);
    enqueue(32'h4C, 1'b0, 32'h0, 8'h13);
    checkOutput("fullReady", 32'(pred_ready), 32'd0);
    pushExp(1'b1, 8'h10, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 32'h2000, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    checkOutput("readyCount3", 32'(pred_ready), 32'd1);
    pushExp(1'b1, 8'h11, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    pushExp(1'b1, 8'h12, 1'b1, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h90);
    pushExp(1'b1, 8'h13, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    pushExp(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    idleCycles(1);

    // Mispredict discards a same-cycle enqueue; the next resolve finds an empty queue.
    enqueue(32'h300, 1'b0, 32'h0, 8'h3C);
    pushExp(1'b1, 8'hC0, 1'b1, 1'b1, 32'h400, 8'h79, 1'b0);
    applyStimulus(1'b1, 32'h304, 1'b0, '0, 8'h3D, 1'b1, 1'b1, 32'h400);
    idleCycles(1);
    pushExp(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    idleCycles(2);

    // Async reset in RECOVER clears the pending flush before the next edge.
    enqueue(32'h600, 1'b1, 32'h700, 8'h01);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    checkOutput("flushBeforeReset", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midResetReady", 32'(pred_ready), 32'd1);
    checkOutput("midResetStrobes", {28'd0, upd_valid, flush, ghr_restore_valid, res_err}, 32'd0);
    checkOutput("midResetData", 32'(upd_addr) | 32'(ghr_restore) | redirect_pc | 32'(upd_taken), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three resolves, one of them mispredicted.
    enqueue(32'h800, 1'b0, 32'h0, 8'h00);
    enqueue(32'h804, 1'b1, 32'h900, 8'h00);
    pushExp(1'b1, 8'h00, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    pushExp(1'b1, 8'h01, 1'b1, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h900);
    enqueue(32'h808, 1'b1, 32'h900, 8'h80);
    pushExp(1'b1, 8'h02, 1'b0, 1'b1, 32'h80C, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    idleCycles(3);
`ifdef BP_STATS_EN
    checkOutput("stat_branches", stat_branches, 32'd3);
    checkOutput("stat_mispred", stat_mispred, 32'd1);
`endif

    checkOutput("pendingExpected", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
